// File: rtl/register_bank_reader_pkg.sv
// Shared types and constants for the register bank reader.
//   state_t       : reader FSM states (IDLE / SEND / DONE), 2-bit encoding
//   WIDTH_DEFAULT : default bits per register word
//   DEPTH_DEFAULT : default number of registers in the bank
//   IDX_W_DEFAULT : index width for the default depth
//   idx_width()   : index width for an arbitrary depth (at least 1 bit)
package register_bank_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEFAULT = 5;
  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned IDX_W_DEFAULT = $clog2(DEPTH_DEFAULT);

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/register_bank_reader_lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of a mask.
//   mask : DEPTH-bit input mask
//   idx  : index of the lowest set bit (0 when mask is all zero)
//   any  : high when at least one mask bit is set
module lowest_set_index
  import register_bank_reader_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic [DEPTH-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (mask[IDX_W'(i - 1)]) begin
        idx = IDX_W'(i - 1);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_bank_reader.sv
// Register bank reader: on start, snapshots a bank of DEPTH words and
// streams them out over a valid/ready handshake, flagging the final word
// and pulsing done one cycle after the last handshake.
// Optional feature macro: SKIP_ZERO_EN -- when defined, zero words are
// left out of the stream (an all-zero bank produces no beats).
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : one-cycle request to snapshot and stream (IDLE only)
//   bank_data  : flattened bank, word i = bank_data[i*WIDTH +: WIDTH]
//   out_ready  : consumer accepts the current word
//   out_valid  : out_data holds a valid word
//   out_data   : current word (0 when out_valid is low)
//   out_last   : current word is the final word of the stream
//   busy       : high whenever the reader is not IDLE
//   done       : one-cycle pulse after the final handshake
module register_bank_reader
  import register_bank_reader_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [DEPTH*WIDTH-1:0] bank_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  state_t           state;
  logic [WIDTH-1:0] shadow [DEPTH];
  logic [DEPTH-1:0] mask;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0] bank_word [DEPTH];
  logic [DEPTH-1:0] snap_mask;
  logic [DEPTH-1:0] mask_after;
  logic [DEPTH-1:0] enc_in;
  logic [DEPTH-1:0] enc_rest;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_is_last;
  logic [WIDTH-1:0] next_word;
  logic             handshake;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      bank_word[i] = bank_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    snap_mask = '1;
`ifdef SKIP_ZERO_EN
    for (int unsigned i = 0; i < DEPTH; i++) begin
      snap_mask[i] = |bank_data[i*WIDTH +: WIDTH];
    end
`endif
  end

  // One encoder serves both the snapshot (fresh mask from the bank) and
  // each handshake (current mask with the word just sent removed). The
  // word it selects and whether that word is the final one are both
  // registered, so out_valid/out_data/out_last never depend on out_ready
  // combinationally.
  always_comb begin
    mask_after  = mask & ~(DEPTH'(1) << idx);
    enc_in      = (state == IDLE) ? snap_mask : mask_after;
    enc_rest    = enc_in & ~(DEPTH'(1) << enc_idx);
    enc_is_last = (enc_rest == '0);
    next_word   = (state == IDLE) ? bank_word[enc_idx] : shadow[enc_idx];
    handshake   = out_valid && out_ready;
  end

  lowest_set_index #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_lowest_set_index (
    .mask (enc_in),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        shadow[i] <= '0;
      end
      mask      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
              shadow[i] <= bank_word[i];
            end
            mask <= snap_mask;
            busy <= 1'b1;
            if (!enc_any) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= SEND;
              idx       <= enc_idx;
              out_valid <= 1'b1;
              out_data  <= next_word;
              out_last  <= enc_is_last;
            end
          end
        end

        SEND: begin
          if (handshake) begin
            mask <= mask_after;
            if (out_last) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx      <= enc_idx;
              out_data <= next_word;
              out_last <= enc_is_last;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_bank_reader.sv
module tb_register_bank_reader;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned DEPTH = 4;

  logic                   clk;
  logic                   reset_n;
  logic                   start;
  logic [DEPTH*WIDTH-1:0] bank_data;
  logic                   out_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic                   busy;
  logic                   done;

  register_bank_reader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bank_data (bank_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    exp_done;
  int    n_cmp;
  int    n_bad;
  int    rdy_mode;   // 0: always ready, 1: random, 2: driven by stimulus

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DEPTH*WIDTH-1:0] pack(input int unsigned w0, input int unsigned w1,
                                                  input int unsigned w2, input int unsigned w3);
    return {WIDTH'(w3), WIDTH'(w2), WIDTH'(w1), WIDTH'(w0)};
  endfunction

  // Reference model: the stream is the bank words in index order, zero
  // words dropped when skipping is enabled; the final beat carries last.
  task automatic push_stream(input logic [DEPTH*WIDTH-1:0] bank, output int unsigned n);
    logic [WIDTH-1:0] w;
    beat_t b;
    n = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w = bank[i*WIDTH +: WIDTH];
`ifdef SKIP_ZERO_EN
      if (w == '0) continue;
`endif
      b.data = w;
      b.last = 1'b0;
      exp_q.push_back(b);
      n++;
    end
    if (n > 0) exp_q[exp_q.size()-1].last = 1'b1;
    exp_done++;
  endtask

  // Returns at 1 time unit after the edge that samples start (edge E0).
  task automatic issue_start(input logic [DEPTH*WIDTH-1:0] bank, input bit expect_accept,
                             output int unsigned n);
    n = 0;
    @(posedge clk);
    #1;
    bank_data = bank;
    start = 1'b1;
    if (expect_accept) push_stream(bank, n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles after E0 until done is seen; first negedge is cycle 1.
  task automatic wait_done(input int unsigned budget, output int unsigned cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (cyc >= budget) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
    chk("drained", exp_q.size(), 0);
    chk("done_count", exp_done, 0);
    chk("idle_busy", busy, 0);
  endtask

  // Ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
    end
  end

  // Scoreboard monitor.
  initial begin
    beat_t            e;
    bit               prev_hold;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_data);
          chk("hold_last", out_last, prev_last);
        end
        if (out_valid) begin
          chk("busy_in_send", busy, 1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got data %0d, expected no beat", out_data);
          end else begin
            e = exp_q[0];
            chk("beat_data", out_data, e.data);
            chk("beat_last", out_last, e.last);
            if (out_ready) void'(exp_q.pop_front());
          end
        end else begin
          chk("idle_data_zero", out_data, 0);
        end
        if (done) begin
          chk("busy_in_done", busy, 1);
          chk("done_no_valid", out_valid, 0);
          if (exp_done == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done 1, expected 0");
          end else begin
            exp_done--;
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
      end
    end
  end

  // Stimulus.
  initial begin
    int unsigned n, cyc, k;
    logic [DEPTH*WIDTH-1:0] bank;

    n_cmp = 0;
    n_bad = 0;
    exp_done = 0;
    rdy_mode = 0;
    reset_n = 1'b0;
    start = 1'b0;
    bank_data = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Basic stream with ready held high: exact latency.
    rdy_mode = 0;
    issue_start(pack(3, 0, 17, 31), 1'b1, n);
    wait_done(50, cyc);
    chk("latency_basic", cyc, n + 1);
    settle();

    // Backpressure on word 17 for three cycles.
    rdy_mode = 2;
    out_ready = 1'b1;
`ifdef SKIP_ZERO_EN
    k = 2;
`else
    k = 3;
`endif
    issue_start(pack(3, 0, 17, 31), 1'b1, n);
    for (int unsigned j = 1; j <= k + 2; j++) begin
      out_ready = (j >= k) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (j >= k) begin
        chk("bp_valid", out_valid, 1);
        chk("bp_data17", out_data, 17);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_last_hold17", out_data, 17);
    @(negedge clk);
    chk("bp_resume31", out_data, 31);
    chk("bp_resume_last", out_last, 1);
    wait_done(50, cyc);
    settle();

    // Snapshot isolation and ignored start during SEND.
    rdy_mode = 0;
    issue_start(pack(3, 0, 17, 31), 1'b1, n);
    @(posedge clk);
    #1;
    bank_data = '1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(50, cyc);
    settle();
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart_busy", busy, 0);

    // All-zero bank.
    issue_start('0, 1'b1, n);
    wait_done(50, cyc);
    chk("latency_zero_bank", cyc, n + 1);
    settle();

    // Asynchronous reset mid-stream.
    issue_start(pack(3, 0, 17, 31), 1'b1, n);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    exp_q.delete();
    exp_done = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    issue_start(pack(3, 0, 17, 31), 1'b1, n);
    wait_done(50, cyc);
    chk("latency_after_rst", cyc, n + 1);
    settle();

    // Randomized banks with random backpressure.
    rdy_mode = 1;
    for (int unsigned t = 0; t < 30; t++) begin
      bank = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bank[i*WIDTH +: WIDTH] = ($urandom_range(0, 2) == 0) ? WIDTH'(0) : WIDTH'($urandom);
      end
      issue_start(bank, 1'b1, n);
      wait_done(300, cyc);
      settle();
    end

    rdy_mode = 0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
